// File: rtl/vga_timing_pkg.sv
// Shared raster timing defaults and the coordinate type used by the timing
// generator and every downstream mapper.
package vga_timing_pkg;

  typedef logic [9:0] coord_t;

  localparam int H_VIS_DEF  = 640;
  localparam int H_FP_DEF   = 16;
  localparam int H_SYNC_DEF = 96;
  localparam int H_BP_DEF   = 48;

  localparam int V_VIS_DEF  = 480;
  localparam int V_FP_DEF   = 10;
  localparam int V_SYNC_DEF = 2;
  localparam int V_BP_DEF   = 33;

  // Largest axis length a 10-bit coordinate can represent.
  localparam int COORD_LIMIT = 1024;

  function automatic int axis_total(input int vis, input int fp,
                                    input int sync, input int bp);
    return vis + fp + sync + bp;
  endfunction

  localparam int H_TOTAL_DEF = axis_total(H_VIS_DEF, H_FP_DEF, H_SYNC_DEF, H_BP_DEF);
  localparam int V_TOTAL_DEF = axis_total(V_VIS_DEF, V_FP_DEF, V_SYNC_DEF, V_BP_DEF);

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: enabled wrap counter 0..MAX with terminal-count flag and
// a sync-window decode of the position it will show after the next edge.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int MAX     = H_TOTAL_DEF - 1,
  parameter int SYNC_LO = H_VIS_DEF + H_FP_DEF,
  parameter int SYNC_HI = H_VIS_DEF + H_FP_DEF + H_SYNC_DEF
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   en,
  output coord_t count,
  output coord_t count_nxt,
  output logic   tc,
  output logic   sync_nxt
);

  localparam coord_t MAX_C = coord_t'(MAX);

  coord_t count_q;
  coord_t count_d;

  always_comb begin
    tc      = (count_q == MAX_C);
    count_d = count_q;
    if (en) begin
      count_d = tc ? '0 : count_q + 1'b1;
    end
  end

  // Compared as int so a window ending exactly at 1024 still decodes.
  always_comb begin
    sync_nxt = (int'(count_d) >= SYNC_LO) && (int'(count_d) < SYNC_HI);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= MAX_C;
    end else begin
      count_q <= count_d;
    end
  end

  assign count     = count_q;
  assign count_nxt = count_d;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: position, active-video qualifier, syncs and
// frame tick/counter, all registered from the decoded next position.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   H_VIS    = H_VIS_DEF,
  parameter int   H_FP     = H_FP_DEF,
  parameter int   H_SYNC   = H_SYNC_DEF,
  parameter int   H_BP     = H_BP_DEF,
  parameter int   V_VIS    = V_VIS_DEF,
  parameter int   V_FP     = V_FP_DEF,
  parameter int   V_SYNC   = V_SYNC_DEF,
  parameter int   V_BP     = V_BP_DEF,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic        vga_clk,
  input  logic        reset,
  output logic [9:0]  DrawX,
  output logic [9:0]  DrawY,
  output logic        blank,
  output logic        hs,
  output logic        vs,
  output logic        line_start,
  output logic        frame_start,
  output logic [15:0] frame_count
);

  localparam int H_TOTAL = axis_total(H_VIS, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = axis_total(V_VIS, V_FP, V_SYNC, V_BP);

  generate
    if (H_TOTAL > COORD_LIMIT || V_TOTAL > COORD_LIMIT) begin : g_bad_size
      $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed 10-bit coordinate range");
    end
  endgenerate

  coord_t x_cur, x_nxt, y_cur, y_nxt;
  logic   h_tc, v_tc, h_sync_nxt, v_sync_nxt;

  vga_axis_counter #(
    .MAX     (H_TOTAL - 1),
    .SYNC_LO (H_VIS + H_FP),
    .SYNC_HI (H_VIS + H_FP + H_SYNC)
  ) u_h (
    .clk       (vga_clk),
    .rst       (reset),
    .en        (1'b1),
    .count     (x_cur),
    .count_nxt (x_nxt),
    .tc        (h_tc),
    .sync_nxt  (h_sync_nxt)
  );

  // Vertical advances only on the horizontal wrap edge.
  vga_axis_counter #(
    .MAX     (V_TOTAL - 1),
    .SYNC_LO (V_VIS + V_FP),
    .SYNC_HI (V_VIS + V_FP + V_SYNC)
  ) u_v (
    .clk       (vga_clk),
    .rst       (reset),
    .en        (h_tc),
    .count     (y_cur),
    .count_nxt (y_nxt),
    .tc        (v_tc),
    .sync_nxt  (v_sync_nxt)
  );

  logic        blank_q, blank_d;
  logic        hs_q, hs_d;
  logic        vs_q, vs_d;
  logic        line_start_q, line_start_d;
  logic        frame_start_q, frame_start_d;
  logic [15:0] frame_count_q, frame_count_d;

  // Everything below describes the position entered on the coming edge,
  // so the registered outputs line up with the registered coordinates.
  always_comb begin
    blank_d       = (int'(x_nxt) < H_VIS) && (int'(y_nxt) < V_VIS);
    hs_d          = h_sync_nxt ? SYNC_POL : ~SYNC_POL;
    vs_d          = v_sync_nxt ? SYNC_POL : ~SYNC_POL;
    line_start_d  = h_tc;
    frame_start_d = h_tc && v_tc;
    frame_count_d = frame_count_q;
    if (frame_start_d) begin
      frame_count_d = frame_count_q + 16'd1;
    end
  end

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      blank_q       <= 1'b0;
      hs_q          <= ~SYNC_POL;
      vs_q          <= ~SYNC_POL;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_count_q <= 16'hFFFF;
    end else begin
      blank_q       <= blank_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign DrawX       = x_cur;
  assign DrawY       = y_cur;
  assign blank       = blank_q;
  assign hs          = hs_q;
  assign vs          = vs_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default 640x480 timing plus a tiny
// active-high-sync configuration for wrap and frame-counter rollover.
module tb_vga_timing_gen;

  logic        vga_clk = 1'b0;
  logic        reset;
  logic        reset_s;

  logic [9:0]  x, y;
  logic        blank, hs, vs, line_start, frame_start;
  logic [15:0] frame_count;

  logic [9:0]  s_x, s_y;
  logic        s_blank, s_hs, s_vs, s_line_start, s_frame_start;
  logic [15:0] s_frame_count;

  int n_checks = 0;
  int n_errors = 0;

  always #5 vga_clk = ~vga_clk;

  vga_timing_gen dut (
    .vga_clk     (vga_clk),
    .reset       (reset),
    .DrawX       (x),
    .DrawY       (y),
    .blank       (blank),
    .hs          (hs),
    .vs          (vs),
    .line_start  (line_start),
    .frame_start (frame_start),
    .frame_count (frame_count)
  );

  vga_timing_gen #(
    .H_VIS(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_VIS(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .SYNC_POL(1'b1)
  ) dut_s (
    .vga_clk     (vga_clk),
    .reset       (reset_s),
    .DrawX       (s_x),
    .DrawY       (s_y),
    .blank       (s_blank),
    .hs          (s_hs),
    .vs          (s_vs),
    .line_start  (s_line_start),
    .frame_start (s_frame_start),
    .frame_count (s_frame_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge vga_clk);
      #1;
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_x"},  32'(x), 32'd799);
    chk({tag, "_y"},  32'(y), 32'd524);
    chk({tag, "_blank"}, 32'(blank), 32'd0);
    chk({tag, "_hs"}, 32'(hs), 32'd1);
    chk({tag, "_vs"}, 32'(vs), 32'd1);
    chk({tag, "_ls"}, 32'(line_start), 32'd0);
    chk({tag, "_fs"}, 32'(frame_start), 32'd0);
    chk({tag, "_fc"}, 32'(frame_count), 32'hFFFF);
  endtask

  initial begin
    int hs_low, hs_first, hs_last, blank_fall;
    int vs_low, vs_first, vs_last, fs_at;
    int ex, ey;

    reset   = 1'b1;
    reset_s = 1'b1;

    // Reset state held over several edges
    step(5);
    chk_reset_state("rst");

    // First edge after release enters (0,0)
    reset = 1'b0;
    step(1);
    chk("rel_x", 32'(x), 32'd0);
    chk("rel_y", 32'(y), 32'd0);
    chk("rel_blank", 32'(blank), 32'd1);
    chk("rel_fs", 32'(frame_start), 32'd1);
    chk("rel_ls", 32'(line_start), 32'd1);
    chk("rel_fc", 32'(frame_count), 32'd0);
    chk("rel_hs", 32'(hs), 32'd1);
    chk("rel_vs", 32'(vs), 32'd1);

    // Line 0 scan: i is the expected DrawX after each edge
    hs_low = 0; hs_first = -1; hs_last = -1; blank_fall = -1;
    for (int i = 1; i < 800; i++) begin
      step(1);
      if (hs === 1'b0) begin
        hs_low++;
        if (hs_first < 0) hs_first = i;
        hs_last = i;
      end
      if (blank === 1'b0 && blank_fall < 0) blank_fall = i;
    end
    chk("l0_x_end", 32'(x), 32'd799);
    chk("l0_y_end", 32'(y), 32'd0);
    chk("l0_hs_cycles", 32'(hs_low), 32'd96);
    chk("l0_hs_first", 32'(hs_first), 32'd656);
    chk("l0_hs_last", 32'(hs_last), 32'd751);
    chk("l0_blank_fall", 32'(blank_fall), 32'd640);
    chk("l0_ls_mid", 32'(line_start), 32'd0);
    step(1);
    chk("l1_x", 32'(x), 32'd0);
    chk("l1_y", 32'(y), 32'd1);
    chk("l1_ls", 32'(line_start), 32'd1);
    chk("l1_fs", 32'(frame_start), 32'd0);
    chk("l1_blank", 32'(blank), 32'd1);

    // Jump to line 488 and run to the next frame start
    force dut.u_v.count_q = 10'd488;
    #1;
    release dut.u_v.count_q;
    vs_low = 0; vs_first = -1; vs_last = -1; fs_at = -1;
    for (int c = 1; c <= 30000; c++) begin
      step(1);
      if (vs === 1'b0) begin
        vs_low++;
        if (vs_first < 0) vs_first = c;
        vs_last = c;
      end
      if (frame_start === 1'b1) begin
        fs_at = c;
        break;
      end
    end
    chk("fr_vs_cycles", 32'(vs_low), 32'd1600);
    chk("fr_vs_first", 32'(vs_first), 32'd1600);
    chk("fr_vs_last", 32'(vs_last), 32'd3199);
    chk("fr_fs_at", 32'(fs_at), 32'd29600);
    chk("fr_x", 32'(x), 32'd0);
    chk("fr_y", 32'(y), 32'd0);
    chk("fr_fc", 32'(frame_count), 32'd1);

    // Mid-frame async reset at (300,200)
    force dut.u_v.count_q = 10'd200;
    #1;
    release dut.u_v.count_q;
    step(300);
    chk("mid_x", 32'(x), 32'd300);
    chk("mid_y", 32'(y), 32'd200);
    chk("mid_blank", 32'(blank), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk_reset_state("arst");
    step(2);
    chk_reset_state("arst_hold");
    reset = 1'b0;
    step(1);
    chk("rst2_x", 32'(x), 32'd0);
    chk("rst2_y", 32'(y), 32'd0);
    chk("rst2_fs", 32'(frame_start), 32'd1);
    chk("rst2_fc", 32'(frame_count), 32'd0);

    // Small configuration: 8x6 raster, active-high syncs
    chk("s_rst_x", 32'(s_x), 32'd7);
    chk("s_rst_y", 32'(s_y), 32'd5);
    chk("s_rst_hs", 32'(s_hs), 32'd0);
    chk("s_rst_vs", 32'(s_vs), 32'd0);
    reset_s = 1'b0;
    for (int k = 0; k < 48; k++) begin
      step(1);
      ex = k % 8;
      ey = k / 8;
      chk("s_x", 32'(s_x), 32'(ex));
      chk("s_y", 32'(s_y), 32'(ey));
      chk("s_blank", 32'(s_blank), 32'(ex < 4 && ey < 3));
      chk("s_hs", 32'(s_hs), 32'(ex >= 5 && ex <= 6));
      chk("s_vs", 32'(s_vs), 32'(ey == 4));
      chk("s_fs", 32'(s_frame_start), 32'(k == 0));
      chk("s_fc", 32'(s_frame_count), 32'd0);
    end
    step(1);
    chk("s_f1_x", 32'(s_x), 32'd0);
    chk("s_f1_y", 32'(s_y), 32'd0);
    chk("s_f1_fc", 32'(s_frame_count), 32'd1);

    // Frame counter rollover from a preloaded FFFF
    force dut_s.frame_count_q = 16'hFFFF;
    #1;
    release dut_s.frame_count_q;
    step(47);
    chk("s_pre_x", 32'(s_x), 32'd7);
    chk("s_pre_y", 32'(s_y), 32'd5);
    chk("s_pre_fc", 32'(s_frame_count), 32'hFFFF);
    step(1);
    chk("s_wrap_fc", 32'(s_frame_count), 32'd0);
    chk("s_wrap_fs", 32'(s_frame_start), 32'd1);
    chk("s_wrap_x", 32'(s_x), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
